dcache_req_arb: RTL

- Shares the single dcache request/response port between two requesters: port 0 = LSU (load/store queue requests), port 1 = page-table walker (PTW, loads only).
- Round-robin arbitration feeds a one-entry registered output stage.
- A source bit is prepended to the request index, and responses are routed back by that bit.
- Per-source outstanding counters throttle requests; flush discards stale LSU responses.

---
 rtl/dcache_req_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dcache_req_arb.sv
// dcache_req_arb: shares one dcache request/response port between the LSU
// (source 0) and the page-table walker (source 1, loads only).
//   s0_req_*  : LSU request (valid/ready + opcode/sign/size/addr/data/id)
//   s1_req_*  : PTW request (valid/ready + addr/id)
//   dc_req_*  : registered one-entry request stage towards the dcache,
//               id = {src, requester id}
//   dc_resp_* : dcache response, routed back combinationally by id MSB
//   s0/s1_resp_* : per-source response outputs
//   flush     : cancels an unaccepted LSU entry and drops in-flight LSU
//               responses; PTW traffic is untouched.
module dcache_req_arb #(
  parameter int XLEN             = 64,
  parameter int VIRTUAL_ADDR_LEN = 39,
  parameter int ID_W             = 4,
  parameter int MAX_OUT          = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        s0_req_valid_i,
  output logic                        s0_req_ready_o,
  input  logic                        s0_req_opcode_i,
  input  logic                        s0_req_sign_i,
  input  logic [1:0]                  s0_req_size_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0] s0_req_addr_i,
  input  logic [XLEN-1:0]             s0_req_data_i,
  input  logic [ID_W-1:0]             s0_req_id_i,
  input  logic                        s1_req_valid_i,
  output logic                        s1_req_ready_o,
  input  logic [VIRTUAL_ADDR_LEN-1:0] s1_req_addr_i,
  input  logic [ID_W-1:0]             s1_req_id_i,
  output logic                        dc_req_valid_o,
  input  logic                        dc_req_ready_i,
  output logic                        dc_req_opcode_o,
  output logic                        dc_req_sign_o,
  output logic [1:0]                  dc_req_size_o,
  output logic [VIRTUAL_ADDR_LEN-1:0] dc_req_addr_o,
  output logic [XLEN-1:0]             dc_req_data_o,
  output logic [ID_W:0]               dc_req_id_o,
  input  logic                        dc_resp_valid_i,
  output logic                        dc_resp_ready_o,
  input  logic [ID_W:0]               dc_resp_id_i,
  input  logic [XLEN-1:0]             dc_resp_data_i,
  output logic                        s0_resp_valid_o,
  input  logic                        s0_resp_ready_i,
  output logic [ID_W-1:0]             s0_resp_id_o,
  output logic [XLEN-1:0]             s0_resp_data_o,
  output logic                        s1_resp_valid_o,
  input  logic                        s1_resp_ready_i,
  output logic [ID_W-1:0]             s1_resp_id_o,
  output logic [XLEN-1:0]             s1_resp_data_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

  logic                        full_q, src_q, rr_q;
  logic                        op_q, sign_q;
  logic [1:0]                  size_q;
  logic [VIRTUAL_ADDR_LEN-1:0] addr_q;
  logic [XLEN-1:0]             data_q;
  logic [ID_W-1:0]             id_q;
  logic [CW-1:0]               cnt0_q, cnt1_q, drain_q;
  logic [CW-1:0]               cnt0_d, cnt1_d, drain_d;

  logic can_load, draining, elig0, elig1, gnt0, gnt1, fire0, fire1;
  logic resp_src, drop, rfire0, rfire1, cancel;

  assign can_load = ~full_q | dc_req_ready_i;
  assign draining = (drain_q != '0);

  // Eligibility uses registered counters, so a same-cycle response cannot
  // open a slot for a new request.
  assign elig0 = s0_req_valid_i & (cnt0_q < MAXC) & ~flush & ~draining;
  assign elig1 = s1_req_valid_i & (cnt1_q < MAXC);
  // rr_q = 0 prefers LSU when both compete.
  assign gnt0  = elig0 & (~elig1 | ~rr_q);
  assign gnt1  = elig1 & ~gnt0;
  assign fire0 = can_load & gnt0;
  assign fire1 = can_load & gnt1;
  assign s0_req_ready_o = fire0;
  assign s1_req_ready_o = fire1;

  // An LSU entry still waiting in the output stage when flush hits is
  // withdrawn; it never reaches the dcache, so it owes no response.
  assign cancel = flush & full_q & ~src_q & ~dc_req_ready_i;

  assign resp_src        = dc_resp_id_i[ID_W];
  assign drop            = ~resp_src & draining;
  assign dc_resp_ready_o = resp_src ? s1_resp_ready_i : (drop | s0_resp_ready_i);
  assign rfire0          = dc_resp_valid_i & dc_resp_ready_o & ~resp_src;
  assign rfire1          = dc_resp_valid_i & dc_resp_ready_o & resp_src;

  assign s0_resp_valid_o = dc_resp_valid_i & ~resp_src & ~drop;
  assign s0_resp_id_o    = dc_resp_id_i[ID_W-1:0];
  assign s0_resp_data_o  = dc_resp_data_i;
  assign s1_resp_valid_o = dc_resp_valid_i & resp_src;
  assign s1_resp_id_o    = dc_resp_id_i[ID_W-1:0];
  assign s1_resp_data_o  = dc_resp_data_i;

  assign dc_req_valid_o  = full_q;
  assign dc_req_opcode_o = op_q;
  assign dc_req_sign_o   = sign_q;
  assign dc_req_size_o   = size_q;
  assign dc_req_addr_o   = addr_q;
  assign dc_req_data_o   = data_q;
  assign dc_req_id_o     = {src_q, id_q};

  always_comb begin
    cnt0_d  = cnt0_q + CW'(fire0) - CW'(rfire0) - CW'(cancel);
    cnt1_d  = cnt1_q + CW'(fire1) - CW'(rfire1);
    drain_d = drain_q;
    // Everything LSU still owes after this edge is stale.
    if (flush)
      drain_d = cnt0_q - CW'(rfire0) - CW'(cancel);
    else if (rfire0 & drop)
      drain_d = drain_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      src_q   <= 1'b0;
      rr_q    <= 1'b0;
      op_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      drain_q <= '0;
    end else begin
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      drain_q <= drain_d;
      if (cancel) begin
        full_q <= 1'b0;
      end else if (can_load) begin
        full_q <= fire0 | fire1;
        if (fire0) begin
          src_q  <= 1'b0;
          op_q   <= s0_req_opcode_i;
          sign_q <= s0_req_sign_i;
          size_q <= s0_req_size_i;
          addr_q <= s0_req_addr_i;
          data_q <= s0_req_data_i;
          id_q   <= s0_req_id_i;
          rr_q   <= 1'b1;
        end else if (fire1) begin
          // PTE fetch: unsigned doubleword load.
          src_q  <= 1'b1;
          op_q   <= 1'b0;
          sign_q <= 1'b0;
          size_q <= 2'b11;
          addr_q <= s1_req_addr_i;
          data_q <= '0;
          id_q   <= s1_req_id_i;
          rr_q   <= 1'b0;
        end
      end
    end
  end

endmodule
